// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and data_mem_responder.
// Signal suffixes are named from the responder's point of view.
interface data_mem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] rdata_o;
    logic        err_o;

    // A transfer happens on a rising edge where valid and ready are both 1;
    // valid and its payload are held stable by the sender until that edge.
    modport slave (
        input  req_valid_i, req_write_i, addr_i, wdata_i, resp_ready_i,
        output req_ready_o, resp_valid_o, rdata_o, err_o
    );

    modport master (
        output req_valid_i, req_write_i, addr_i, wdata_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, rdata_o, err_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data memory responder with programmable wait states (IDLE/WAIT/RESP).
// Optional address checking is enabled by defining DMEM_ERR_CHECK_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    data_mem_responder_if.slave   bus,
    output logic [1:0]            state_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q, valid_q, write_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept, enter_resp, acc_write, acc_err;
    logic [31:0]   acc_addr, acc_wdata;
    logic [AW-1:0] acc_idx;

    assign accept     = (state_q == IDLE) && ready_q && bus.req_valid_i;
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));

    // With zero wait states the access happens on the accept edge itself,
    // so the live request fields are used instead of the latched copies.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_write = bus.req_write_i;
            acc_addr  = bus.addr_i;
            acc_wdata = bus.wdata_i;
        end
    end

    assign acc_idx = acc_addr[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    assign acc_err = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= ADDR_LIMIT);
`else
    logic unused_addr_bits;
    assign acc_err          = 1'b0;
    assign unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q <= bus.req_write_i;
                        addr_q  <= bus.addr_i;
                        wdata_q <= bus.wdata_i;
                        ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                if (acc_err) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else if (acc_write) begin
                    mem_q[acc_idx] <= acc_wdata;
                    rdata_q        <= '0;
                    err_q          <= 1'b0;
                end else begin
                    rdata_q <= mem_q[acc_idx];
                    err_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready_o  = ready_q;
    assign bus.resp_valid_o = valid_q;
    assign bus.rdata_o      = rdata_q;
    assign bus.err_o        = err_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with 2 wait states, one with none.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] state_a, state_b;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  data_mem_responder_if a_if ();
  data_mem_responder_if b_if ();

  data_mem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(a_if), .state_o(state_a)
  );
  data_mem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(b_if), .state_o(state_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    a_if.req_valid_i = 1'b0; a_if.req_write_i = 1'b0; a_if.addr_i = '0; a_if.wdata_i = '0;
    a_if.resp_ready_i = 1'b0;
    b_if.req_valid_i = 1'b0; b_if.req_write_i = 1'b0; b_if.addr_i = '0; b_if.wdata_i = '0;
    b_if.resp_ready_i = 1'b0;
  endtask

  // sel=0 targets the 2-wait-state instance, sel=1 the zero-wait instance.
  task automatic txn(input bit sel, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input bit exp_err, input string tag);
    int lat;
    bit got;
    logic [31:0] exp_rd;
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    if (sel) begin
      b_if.req_valid_i = 1'b1; b_if.req_write_i = wr; b_if.addr_i = addr; b_if.wdata_i = wdata;
    end else begin
      a_if.req_valid_i = 1'b1; a_if.req_write_i = wr; a_if.addr_i = addr; a_if.wdata_i = wdata;
    end
    chk({tag, ".req_ready"}, {31'd0, sel ? b_if.req_ready_o : a_if.req_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    a_if.req_valid_i = 1'b0;
    b_if.req_valid_i = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if ((sel ? b_if.resp_valid_o : a_if.resp_valid_o) === 1'b1) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({tag, ".latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
    exp_rd = exp_q.pop_front();
    chk({tag, ".rdata"}, sel ? b_if.rdata_o : a_if.rdata_o, exp_rd);
    chk({tag, ".err"}, {31'd0, sel ? b_if.err_o : a_if.err_o}, {31'd0, exp_err});
    if (sel) b_if.resp_ready_i = 1'b1; else a_if.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    a_if.resp_ready_i = 1'b0;
    b_if.resp_ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    idle_inputs();

    // Reset: both instances held for three edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", {31'd0, a_if.req_ready_o}, 32'd0);
    chk("rst.resp_valid", {31'd0, a_if.resp_valid_o}, 32'd0);
    chk("rst.rdata", a_if.rdata_o, 32'd0);
    chk("rst.err", {31'd0, a_if.err_o}, 32'd0);
    chk("rst.state", {30'd0, state_a}, 32'd0);
    chk("rst.b_req_ready", {31'd0, b_if.req_ready_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst.req_ready", {31'd0, a_if.req_ready_o}, 32'd1);
    chk("post_rst.b_req_ready", {31'd0, b_if.req_ready_o}, 32'd1);

    // Zero-wait instance: load of an untouched word answers next cycle with 0
    txn(1'b1, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, "b_load04");
    txn(1'b1, 1'b1, 32'h08, 32'hCAFE0001, 32'h0, 1'b0, "b_store08");
    txn(1'b1, 1'b0, 32'h08, 32'h0, 32'hCAFE0001, 1'b0, "b_load08");

    // Store then load, two wait states
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "store10");
    txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "load10");
    txn(1'b0, 1'b1, 32'h1FC, 32'h0BADF00D, 32'h0, 1'b0, "store1fc");
    txn(1'b0, 1'b0, 32'h1FC, 32'h0, 32'h0BADF00D, 1'b0, "load1fc");
    txn(1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, "load14");

    // Response held for five cycles while a competing store is presented
    @(negedge clk);
    a_if.req_valid_i = 1'b1; a_if.req_write_i = 1'b0; a_if.addr_i = 32'h10;
    @(posedge clk);
    #1;
    a_if.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold.enter", {31'd0, a_if.resp_valid_o}, 32'd1);
    held = a_if.rdata_o;
    chk("hold.rdata0", held, 32'hDEADBEEF);
    a_if.req_valid_i = 1'b1; a_if.req_write_i = 1'b1; a_if.addr_i = 32'h10; a_if.wdata_i = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold.resp_valid", {31'd0, a_if.resp_valid_o}, 32'd1);
      chk("hold.rdata", a_if.rdata_o, 32'hDEADBEEF);
      chk("hold.req_ready", {31'd0, a_if.req_ready_o}, 32'd0);
    end
    a_if.req_valid_i = 1'b0; a_if.req_write_i = 1'b0;
    a_if.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    a_if.resp_ready_i = 1'b0;
    @(negedge clk);
    chk("hold.back_idle", {30'd0, state_a}, 32'd0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "hold.ignored_store");

    // Reset during WAIT of a store discards it and clears memory
    @(negedge clk);
    a_if.req_valid_i = 1'b1; a_if.req_write_i = 1'b1; a_if.addr_i = 32'h20; a_if.wdata_i = 32'h12345678;
    @(posedge clk);
    #1;
    a_if.req_valid_i = 1'b0;
    @(negedge clk);
    chk("midrst.in_wait", {30'd0, state_a}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.state", {30'd0, state_a}, 32'd0);
    chk("midrst.resp_valid", {31'd0, a_if.resp_valid_o}, 32'd0);
    rst = 1'b1;
    txn(1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, "midrst.load20");
    txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, "midrst.load10");

`ifdef DMEM_ERR_CHECK_EN
    txn(1'b0, 1'b1, 32'h202, 32'h55555555, 32'h0, 1'b1, "err.store202");
    txn(1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, "err.load200");
    txn(1'b0, 1'b0, 32'h000, 32'h0, 32'h0, 1'b0, "err.load000");
`else
    txn(1'b0, 1'b1, 32'h200, 32'hA5A5A5A5, 32'h0, 1'b0, "wrap.store200");
    txn(1'b0, 1'b0, 32'h000, 32'h0, 32'hA5A5A5A5, 1'b0, "wrap.load000");
    txn(1'b0, 1'b1, 32'h33, 32'h11223344, 32'h0, 1'b0, "lsb.store33");
    txn(1'b0, 1'b0, 32'h30, 32'h0, 32'h11223344, 1'b0, "lsb.load30");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 128, number of 32-bit words in the storage array (power of two, 2..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between request accept and response (0..15).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready_o  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port addr_i  input  32  byte address.
REQ-009 SHALL have port wdata_i  input  32  store data.
REQ-010 SHALL have port resp_valid_o  output  1  response available.
REQ-011 SHALL have port resp_ready_i  input  1  initiator consumes response.
REQ-012 SHALL have port rdata_o  output  32  load data; 0 for store responses.
REQ-013 SHALL have port err_o  output  1  response carries an error (present only with DMEM_ERR_CHECK_EN; tied 0 otherwise).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready_o = 1 only in IDLE; resp_valid_o = 1 only in RESP.
REQ-016 SHALL accept a request on a cycle with req_valid_i & req_ready_o, latching req_write_i, addr_i, wdata_i.
REQ-017 On accept with WAIT_CYCLES > 0 SHALL go IDLE->WAIT and load a 4-bit wait counter with WAIT_CYCLES-1; with WAIT_CYCLES = 0 SHALL go IDLE->RESP.
REQ-018 In WAIT SHALL decrement the counter each cycle and go WAIT->RESP in the cycle the counter is 0.
REQ-019 SHALL perform the access on the transition into RESP: store writes latched data to word index addr[log2(DEPTH_WORDS)+1:2]; load registers that word into rdata_o.
REQ-020 SHALL produce resp_valid_o exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 SHALL hold resp_valid_o, rdata_o, err_o stable in RESP until resp_ready_i = 1; on that edge go RESP->IDLE.
REQ-022 SHALL not accept a new request in the cycle resp_ready_i is sampled (no back-to-back overlap); next accept earliest one cycle after leaving RESP.
REQ-023 SHALL ignore req_* inputs outside IDLE; address bits [1:0] SHALL be ignored for indexing.
REQ-024 A load following a store to the same word SHALL return the stored value.

Reset
REQ-025 When rst_i = 0 at a rising edge SHALL enter IDLE, clear wait counter, rdata_o = 0, resp_valid_o = 0, err_o = 0, and zero all storage words.
REQ-026 Reset mid-operation (WAIT or RESP) SHALL discard the pending request; an in-flight store not yet committed SHALL NOT be written.
REQ-027 req_ready_o SHALL read 0 during reset and 1 in the first cycle after rst_i returns to 1.

Configuration
REQ-028 Macro DMEM_ERR_CHECK_EN defined: a request with addr[1:0] != 0 or addr >= 4*DEPTH_WORDS SHALL complete with err_o = 1, rdata_o = 0, no storage write, same latency.
REQ-029 Macro DMEM_ERR_CHECK_EN undefined: no checking; address SHALL wrap modulo 4*DEPTH_WORDS; err_o tied 0.

Verification
REQ-030 Reset then store 0xDEADBEEF to addr 0x10, load addr 0x10 -> rdata_o = 0xDEADBEEF, resp_valid_o exactly 3 cycles after each accept (WAIT_CYCLES = 2).
REQ-031 WAIT_CYCLES = 0, load addr 0x04 after reset -> resp_valid_o next cycle, rdata_o = 0x00000000.
REQ-032 Hold resp_ready_i = 0 for 5 cycles in RESP -> resp_valid_o and rdata_o stable, req_ready_o = 0, concurrent req_valid_i ignored.
REQ-033 Assert rst_i = 0 during WAIT of a store of 0x12345678 to 0x20 -> IDLE next cycle; later load 0x20 returns 0.
REQ-034 With DMEM_ERR_CHECK_EN, store to 0x202 (DEPTH_WORDS = 128) -> err_o = 1; then load 0x200 -> err_o = 1, rdata_o = 0.
REQ-035 Without DMEM_ERR_CHECK_EN, store 0xA5A5A5A5 to 0x200 -> load 0x000 returns 0xA5A5A5A5 (wrap).
